// File: rtl/dac_mix_scheduler.sv
// dac_mix_scheduler: time-multiplexed mixer of NUM_SRC signed sources into one
// offset-binary DAC sample every DAC_FREQ_DIV clocks. Phase i (< NUM_SRC)
// samples source i into a shared accumulator; phase NUM_SRC saturates the sum
// and registers the DAC code; remaining phases idle.
module dac_mix_scheduler #(
    parameter int unsigned DAC_BIT_WIDTH = 10,
    parameter int unsigned DAC_FREQ_DIV  = 5,
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned SRC_WIDTH     = 16
) (
    input  logic                           CLK,
    input  logic                           RESET_n,
    input  logic [NUM_SRC*SRC_WIDTH-1:0]   SRC_DATA,
    input  logic [NUM_SRC*4-1:0]           SRC_GAIN,
    input  logic [NUM_SRC-1:0]             SRC_EN,
    input  logic                           MUTE,
    input  logic                           CLIP_CLR,
    output logic [NUM_SRC-1:0]             SRC_ACK,
    output logic [DAC_BIT_WIDTH-1:0]       DAC_DATA,
    output logic                           DAC_STB,
    output logic                           CLIP
);

    localparam int unsigned PHASE_W = (DAC_FREQ_DIV > 1) ? $clog2(DAC_FREQ_DIV) : 1;
    localparam int unsigned ACC_W   = SRC_WIDTH + 4;
    localparam int unsigned PROD_W  = SRC_WIDTH + 5;
    localparam int unsigned TERM_W  = PROD_W - 3;
    localparam int unsigned SHIFT   = SRC_WIDTH - DAC_BIT_WIDTH;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DAC_FREQ_DIV - 1);
    localparam logic [PHASE_W-1:0] MIX_PHASE  = PHASE_W'(NUM_SRC);

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (DAC_BIT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    localparam logic [DAC_BIT_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_BIT_WIDTH - 1){1'b0}}};

    // Elaboration guards: the schedule needs one phase per source plus the mix phase
    if (DAC_FREQ_DIV < NUM_SRC + 1) begin : g_bad_div
        $error("dac_mix_scheduler: DAC_FREQ_DIV must be at least NUM_SRC+1");
    end
    if (SRC_WIDTH < DAC_BIT_WIDTH) begin : g_bad_width
        $error("dac_mix_scheduler: SRC_WIDTH must not be smaller than DAC_BIT_WIDTH");
    end

    // State
    logic                            run_q, run_d;
    logic [PHASE_W-1:0]              phase_q, phase_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [NUM_SRC-1:0]              ack_q, ack_d;
    logic [DAC_BIT_WIDTH-1:0]        dac_q, dac_d;
    logic                            stb_q, stb_d;
    logic                            clip_q, clip_d;

    // Datapath intermediates
    logic signed [PROD_W-1:0]        prod_c [NUM_SRC];
    logic signed [TERM_W-1:0]        term_c [NUM_SRC];
    logic signed [TERM_W-1:0]        sel_term_c;
    logic signed [ACC_W-1:0]         shifted_c;
    logic signed [ACC_W-1:0]         sat_c;
    logic                            sat_hit_c;
    logic [DAC_BIT_WIDTH-1:0]        s_c;

    // Per-source gained term: (data * zero-extended gain) >>> 3, zero when disabled
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            prod_c[i] = PROD_W'($signed(SRC_DATA[i*SRC_WIDTH +: SRC_WIDTH]))
                      * PROD_W'($signed({1'b0, SRC_GAIN[i*4 +: 4]}));
            term_c[i] = SRC_EN[i] ? TERM_W'(prod_c[i] >>> 3) : '0;
        end
    end

    // Pick the term belonging to the current phase; only that source is sampled
    always_comb begin
        sel_term_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (phase_q == PHASE_W'(i)) begin
                sel_term_c = term_c[i];
            end
        end
    end

    // Scale the accumulated sum to DAC width and saturate to the signed range
    always_comb begin
        shifted_c = acc_q >>> SHIFT;
        sat_c     = shifted_c;
        sat_hit_c = 1'b0;
        if (shifted_c > S_MAX) begin
            sat_c     = S_MAX;
            sat_hit_c = 1'b1;
        end else if (shifted_c < S_MIN) begin
            sat_c     = S_MIN;
            sat_hit_c = 1'b1;
        end
        s_c = DAC_BIT_WIDTH'(sat_c);
    end

    // Next-state: phase sequencing, accumulation, DAC update and clip flag
    always_comb begin
        run_d   = 1'b1;
        phase_d = '0;
        acc_d   = acc_q;
        dac_d   = dac_q;
        stb_d   = 1'b0;
        clip_d  = clip_q;
        ack_d   = '0;

        if (run_q) begin
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
        end

        if (CLIP_CLR) begin
            clip_d = 1'b0;
        end

        if (run_q) begin
            if (phase_q == '0) begin
                acc_d = ACC_W'(sel_term_c);
            end else if (phase_q < MIX_PHASE) begin
                acc_d = acc_q + ACC_W'(sel_term_c);
            end else if (phase_q == MIX_PHASE) begin
                stb_d = 1'b1;
                if (MUTE) begin
                    dac_d = MIDSCALE;
                end else begin
                    dac_d = {~s_c[DAC_BIT_WIDTH-1], s_c[DAC_BIT_WIDTH-2:0]};
                    if (sat_hit_c) begin
                        clip_d = 1'b1;
                    end
                end
            end
        end

        // Acknowledge marks the source whose phase the coming cycle belongs to
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_d[i] = (phase_d == PHASE_W'(i));
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            run_q   <= 1'b0;
            phase_q <= '0;
            acc_q   <= '0;
            ack_q   <= '0;
            dac_q   <= MIDSCALE;
            stb_q   <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            ack_q   <= ack_d;
            dac_q   <= dac_d;
            stb_q   <= stb_d;
            clip_q  <= clip_d;
        end
    end

    assign SRC_ACK  = ack_q;
    assign DAC_DATA = dac_q;
    assign DAC_STB  = stb_q;
    assign CLIP     = clip_q;

endmodule

// File: tb/tb_dac_mix_scheduler.sv
// Bench for dac_mix_scheduler: directed scenarios plus randomized per-cycle
// stimulus, checked every cycle against a frame-level arithmetic model.
module tb_dac_mix_scheduler;

    localparam int W   = 10;
    localparam int DIV = 5;
    localparam int N   = 4;
    localparam int SW  = 16;

    logic              CLK = 1'b0;
    logic              RESET_n;
    logic [N*SW-1:0]   SRC_DATA;
    logic [N*4-1:0]    SRC_GAIN;
    logic [N-1:0]      SRC_EN;
    logic              MUTE;
    logic              CLIP_CLR;
    logic [N-1:0]      SRC_ACK;
    logic [W-1:0]      DAC_DATA;
    logic              DAC_STB;
    logic              CLIP;

    dac_mix_scheduler #(
        .DAC_BIT_WIDTH (W),
        .DAC_FREQ_DIV  (DIV),
        .NUM_SRC       (N),
        .SRC_WIDTH     (SW)
    ) dut (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .SRC_DATA (SRC_DATA),
        .SRC_GAIN (SRC_GAIN),
        .SRC_EN   (SRC_EN),
        .MUTE     (MUTE),
        .CLIP_CLR (CLIP_CLR),
        .SRC_ACK  (SRC_ACK),
        .DAC_DATA (DAC_DATA),
        .DAC_STB  (DAC_STB),
        .CLIP     (CLIP)
    );

    always #5 CLK = ~CLK;

    // Model state: k is the index of the current cycle since reset release
    int  k;
    int  snap_d [N];
    int  snap_g [N];
    bit  snap_en [N];
    int  exp_dac;
    bit  exp_stb;
    bit  exp_clip;
    int  total;
    int  bad;
    int  first_stb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame result from captured inputs, plain integer arithmetic
    function automatic int mix(output bit altered);
        int sum = 0;
        int sh;
        int s;
        int smax = (1 << (W - 1)) - 1;
        int smin = -(1 << (W - 1));
        for (int i = 0; i < N; i++) begin
            if (snap_en[i]) sum += (snap_d[i] * snap_g[i]) >>> 3;
        end
        sh = sum >>> (SW - W);
        s = sh;
        altered = 1'b0;
        if (sh > smax) begin s = smax; altered = 1'b1; end
        if (sh < smin) begin s = smin; altered = 1'b1; end
        return (s + (1 << (W - 1))) & ((1 << W) - 1);
    endfunction

    // Apply the effect of the clock edge that ends a cycle of phase p
    task automatic model_edge(input int p);
        bit setc = 1'b0;
        bit alt;
        exp_stb = 1'b0;
        if (p < N) begin
            snap_d[p]  = int'($signed(SRC_DATA[p*SW +: SW]));
            snap_g[p]  = int'(SRC_GAIN[p*4 +: 4]);
            snap_en[p] = SRC_EN[p];
        end else if (p == N) begin
            exp_stb = 1'b1;
            if (MUTE) begin
                exp_dac = 1 << (W - 1);
            end else begin
                exp_dac = mix(alt);
                setc = alt;
            end
        end
        if (setc) exp_clip = 1'b1;
        else if (CLIP_CLR) exp_clip = 1'b0;
    endtask

    function automatic logic [31:0] exp_ack(input int kk);
        int p = kk % DIV;
        return (p < N) ? (32'd1 << p) : 32'd0;
    endfunction

    task automatic model_reset();
        k = -1;
        exp_dac = 1 << (W - 1);
        exp_stb = 1'b0;
        exp_clip = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dac"},  32'(DAC_DATA), 32'h200);
        chk({tag, "_stb"},  32'(DAC_STB),  32'd0);
        chk({tag, "_ack"},  32'(SRC_ACK),  32'd0);
        chk({tag, "_clip"}, 32'(CLIP),     32'd0);
    endtask

    // One clock: update model for the finished cycle, then compare all outputs
    task automatic tick();
        @(posedge CLK);
        #1;
        if (k >= 0) model_edge(k % DIV);
        k++;
        chk("ack",  32'(SRC_ACK),  exp_ack(k));
        chk("stb",  32'(DAC_STB),  32'(exp_stb));
        chk("dac",  32'(DAC_DATA), 32'(exp_dac));
        chk("clip", 32'(CLIP),     32'(exp_clip));
    endtask

    task automatic align();
        while (k % DIV != 0) tick();
    endtask

    task automatic set_src(input int i, input logic [15:0] d, input logic [3:0] g, input bit en);
        SRC_DATA[i*SW +: SW] = d;
        SRC_GAIN[i*4 +: 4]   = g;
        SRC_EN[i]            = en;
    endtask

    task automatic only_src0(input logic [15:0] d, input logic [3:0] g);
        set_src(0, d, g, 1'b1);
        for (int i = 1; i < N; i++) set_src(i, 16'($urandom), 4'($urandom), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        RESET_n = 1'b0;
        SRC_DATA = '0;
        SRC_GAIN = '0;
        SRC_EN = '0;
        MUTE = 1'b0;
        CLIP_CLR = 1'b0;
        model_reset();

        // Reset values while held
        #23;
        chk_reset_vals("rst");
        @(posedge CLK);
        #1;
        RESET_n = 1'b1;

        // First ACK right after release; first STB five cycles later
        first_stb = -1;
        for (int n = 0; n < 12 && first_stb < 0; n++) begin
            tick();
            if (k == 0) chk("first_ack", 32'(SRC_ACK), 32'd1);
            if (DAC_STB === 1'b1) first_stb = k;
        end
        chk("first_stb_cycle", 32'(first_stb), 32'd5);
        repeat (5) tick();
        chk("stb_period", 32'(DAC_STB), 32'd1);

        // Unity gain, single source
        align();
        only_src0(16'h1000, 4'd8);
        repeat (DIV) tick();
        chk("unity_dac",  32'(DAC_DATA), 32'h240);
        chk("unity_clip", 32'(CLIP),     32'd0);

        // Full-scale positive overload
        align();
        for (int i = 0; i < N; i++) set_src(i, 16'h7FFF, 4'd15, 1'b1);
        repeat (DIV) tick();
        chk("pos_sat_dac",  32'(DAC_DATA), 32'h3FF);
        chk("pos_sat_clip", 32'(CLIP),     32'd1);

        // Clear coinciding with a further clip: set wins
        align();
        repeat (N) tick();
        CLIP_CLR = 1'b1;
        tick();
        CLIP_CLR = 1'b0;
        chk("set_wins_clip", 32'(CLIP), 32'd1);

        // Plain clear
        align();
        only_src0(16'h1000, 4'd8);
        CLIP_CLR = 1'b1;
        tick();
        CLIP_CLR = 1'b0;
        chk("clr_clip", 32'(CLIP), 32'd0);
        repeat (DIV - 1) tick();

        // Negative full scale: exact minimum then overload
        align();
        only_src0(16'h8000, 4'd8);
        repeat (DIV) tick();
        chk("neg_min_dac",  32'(DAC_DATA), 32'h000);
        chk("neg_min_clip", 32'(CLIP),     32'd0);
        align();
        only_src0(16'h8000, 4'd9);
        repeat (DIV) tick();
        chk("neg_sat_dac",  32'(DAC_DATA), 32'h000);
        chk("neg_sat_clip", 32'(CLIP),     32'd1);

        // Mute gives midscale and leaves CLIP alone (set and clear cases)
        align();
        only_src0(16'h1000, 4'd8);
        MUTE = 1'b1;
        repeat (DIV) tick();
        chk("mute_dac",  32'(DAC_DATA), 32'h200);
        chk("mute_stb",  32'(DAC_STB),  32'd1);
        chk("mute_clip", 32'(CLIP),     32'd1);
        CLIP_CLR = 1'b1;
        tick();
        CLIP_CLR = 1'b0;
        align();
        for (int i = 0; i < N; i++) set_src(i, 16'h7FFF, 4'd15, 1'b1);
        repeat (DIV) tick();
        chk("mute_noclip", 32'(CLIP), 32'd0);
        MUTE = 1'b0;

        // Reset in the middle of a frame
        align();
        only_src0(16'h1000, 4'd8);
        repeat (2) tick();
        #2;
        RESET_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        model_reset();
        only_src0(16'h0800, 4'd8);
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_vals("rst_held");
        RESET_n = 1'b1;
        repeat (DIV + 1) tick();
        chk("post_rst_stb", 32'(DAC_STB),  32'd1);
        chk("post_rst_dac", 32'(DAC_DATA), 32'h220);

        // Random inputs changing every cycle
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++) begin
                set_src(i, 16'($urandom), 4'($urandom), 1'($urandom));
            end
            MUTE = ($urandom_range(0, 7) == 0);
            CLIP_CLR = ($urandom_range(0, 9) == 0);
            tick();
        end
        MUTE = 1'b0;
        CLIP_CLR = 1'b0;
        repeat (DIV) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
